// File: rtl/game_flow_ctrl.sv
// Game-phase sequencer for boxhead: title, countdown, play, pause and game-over,
// with all phase timing counted in VGA frames.
module game_flow_ctrl #(
    parameter logic [7:0] START_KEY    = 8'd22,
    parameter logic [7:0] PAUSE_KEY    = 8'd19,
    parameter logic [9:0] SEG_FRAMES   = 10'd60,
    parameter logic [9:0] OVER_FRAMES  = 10'd240,
    parameter logic [9:0] BLINK_FRAMES = 10'd30
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic       player_dead,
    output logic [2:0] state_code,
    output logic       Game_Start_On,
    output logic       Game_Play_On,
    output logic       Game_Pause_On,
    output logic       Game_Over_On,
    output logic [1:0] Countdown_Num,
    output logic       Blink,
    output logic       Game_Reset
);

    typedef enum logic [2:0] {
        TITLE     = 3'd0,
        COUNTDOWN = 3'd1,
        PLAY      = 3'd2,
        PAUSE     = 3'd3,
        OVER      = 3'd4
    } state_t;

    state_t     state, state_next;
    logic       frame_clk_d;
    logic [7:0] keycode_d;
    logic [9:0] frame_cnt, frame_cnt_next;
    logic [9:0] blink_cnt, blink_cnt_next;
    logic [1:0] digit, digit_next;
    logic       blink_q, blink_next;
    logic       game_reset_q, game_reset_next;
    logic       state_change;

    logic frame_tick, press_start, press_pause, seg_done, over_done;

    // Edge detection makes a held key or a long frame strobe count only once.
    assign frame_tick  = frame_clk & ~frame_clk_d;
    assign press_start = (keycode == START_KEY) && (keycode_d != START_KEY);
    assign press_pause = (keycode == PAUSE_KEY) && (keycode_d != PAUSE_KEY);
    assign seg_done    = frame_tick && (frame_cnt == SEG_FRAMES - 10'd1);
    assign over_done   = frame_tick && (frame_cnt == OVER_FRAMES - 10'd1);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= TITLE;
            frame_cnt    <= '0;
            blink_cnt    <= '0;
            digit        <= '0;
            blink_q      <= 1'b1;
            game_reset_q <= 1'b0;
            keycode_d    <= '0;
            frame_clk_d  <= 1'b0;
        end else begin
            state        <= state_next;
            frame_cnt    <= frame_cnt_next;
            blink_cnt    <= blink_cnt_next;
            digit        <= digit_next;
            blink_q      <= blink_next;
            game_reset_q <= game_reset_next;
            keycode_d    <= keycode;
            frame_clk_d  <= frame_clk;
        end
    end

    always_comb begin
        state_next      = state;
        frame_cnt_next  = frame_cnt;
        blink_cnt_next  = blink_cnt;
        digit_next      = digit;
        blink_next      = blink_q;
        game_reset_next = 1'b0;
        state_change    = 1'b0;

        case (state)
            TITLE:     if (press_start) state_next = COUNTDOWN;
            COUNTDOWN: if (seg_done && digit == 2'd1) state_next = PLAY;
            PLAY: begin
                // Death outranks a simultaneous pause press.
                if (player_dead)      state_next = OVER;
                else if (press_pause) state_next = PAUSE;
            end
            PAUSE:     if (press_pause) state_next = PLAY;
            OVER:      if (over_done) state_next = TITLE;
            default:   state_next = TITLE;
        endcase

        state_change = (state_next != state);

        // A state change clears the frame counter even if a tick lands in the same cycle.
        if (state_change || (state == COUNTDOWN && seg_done))
            frame_cnt_next = '0;
        else if (frame_tick)
            frame_cnt_next = frame_cnt + 10'd1;

        if (state_change && state_next == COUNTDOWN) begin
            digit_next      = 2'd3;
            game_reset_next = 1'b1;
        end else if (state == COUNTDOWN && seg_done && digit > 2'd1) begin
            digit_next = digit - 2'd1;
        end

        if (state_change || (state != TITLE && state != PAUSE)) begin
            blink_next     = 1'b1;
            blink_cnt_next = '0;
        end else if (frame_tick) begin
            if (blink_cnt == BLINK_FRAMES - 10'd1) begin
                blink_next     = ~blink_q;
                blink_cnt_next = '0;
            end else begin
                blink_cnt_next = blink_cnt + 10'd1;
            end
        end
    end

    assign state_code    = state;
    assign Game_Start_On = (state == TITLE);
    assign Game_Play_On  = (state == PLAY);
    assign Game_Pause_On = (state == PAUSE);
    assign Game_Over_On  = (state == OVER);
    assign Countdown_Num = (state == COUNTDOWN) ? digit : 2'd0;
    assign Blink         = blink_q;
    assign Game_Reset    = game_reset_q;

endmodule
